// File: rtl/controle_partida.sv
// Match/point sequencer for Pong: clears the scoreboard, times the serve delay,
// issues the serve pulse, tallies goals and flags the end of the match.
`timescale 1ns/1ps

module controle_partida #(
    parameter int PONTOS_VITORIA = 5,
    parameter int ESPERA_SAQUE   = 50,
    parameter int W_PLACAR       = 4,
    parameter int W_ESPERA       = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                pausa,
    input  logic                tick,
    input  logic                gol_esq,
    input  logic                gol_dir,
    output logic [W_PLACAR-1:0] placar_esq,
    output logic [W_PLACAR-1:0] placar_dir,
    output logic                saque,
    output logic                direcao_saque,
    output logic                congela_bola,
    output logic                ganhou,
    output logic                perdeu,
    output logic [2:0]          db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PREPARA = 3'd1,
        ESPERA  = 3'd2,
        SAQUE   = 3'd3,
        JOGO    = 3'd4,
        PONTO   = 3'd5,
        FIM     = 3'd6
    } estado_t;

    localparam logic [W_ESPERA-1:0] ULTIMO_TICK = W_ESPERA'(ESPERA_SAQUE - 1);
    localparam logic [W_PLACAR-1:0] ALVO        = W_PLACAR'(PONTOS_VITORIA);

    estado_t               estado;
    logic [W_ESPERA-1:0]   contador;
    logic                  lado_dir;   // 1 = right side scored the pending point
    logic [W_PLACAR-1:0]   novo_esq;
    logic [W_PLACAR-1:0]   novo_dir;

    // Saturating next scores; the match normally ends before either side saturates.
    always_comb begin
        novo_esq = (placar_esq == '1) ? placar_esq : placar_esq + W_PLACAR'(1);
        novo_dir = (placar_dir == '1) ? placar_dir : placar_dir + W_PLACAR'(1);
    end

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, whatever order the statements appear in.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= OCIOSO;
            placar_esq    <= '0;
            placar_dir    <= '0;
            contador      <= '0;
            direcao_saque <= 1'b1;
            ganhou        <= 1'b0;
            perdeu        <= 1'b0;
            lado_dir      <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: if (iniciar) estado <= PREPARA;
                PREPARA: begin
                    placar_esq    <= '0;
                    placar_dir    <= '0;
                    contador      <= '0;
                    ganhou        <= 1'b0;
                    perdeu        <= 1'b0;
                    direcao_saque <= 1'b1;
                    estado        <= ESPERA;
                end
                ESPERA: begin
                    if (tick && !pausa) begin
                        if (contador == ULTIMO_TICK) begin
                            contador <= '0;
                            estado   <= SAQUE;
                        end else begin
                            contador <= contador + W_ESPERA'(1);
                        end
                    end
                end
                SAQUE: estado <= JOGO;
                JOGO: begin
                    // gol_esq wins a tie; a simultaneous gol_dir is dropped.
                    if (!pausa) begin
                        if (gol_esq) begin
                            lado_dir <= 1'b1;
                            estado   <= PONTO;
                        end else if (gol_dir) begin
                            lado_dir <= 1'b0;
                            estado   <= PONTO;
                        end
                    end
                end
                PONTO: begin
                    contador <= '0;
                    if (lado_dir) begin
                        placar_dir    <= novo_dir;
                        direcao_saque <= 1'b1;
                        if (novo_dir == ALVO) begin
                            perdeu <= 1'b1;
                            estado <= FIM;
                        end else begin
                            estado <= ESPERA;
                        end
                    end else begin
                        placar_esq    <= novo_esq;
                        direcao_saque <= 1'b0;
                        if (novo_esq == ALVO) begin
                            ganhou <= 1'b1;
                            estado <= FIM;
                        end else begin
                            estado <= ESPERA;
                        end
                    end
                end
                FIM: if (iniciar) estado <= PREPARA;
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign saque        = (estado == SAQUE);
    assign congela_bola = !((estado == JOGO) && !pausa);
    assign db_estado    = estado;

endmodule

// File: tb/tb_controle_partida.sv
// Self-checking bench for controle_partida: directed match scenarios plus a
// randomized run, all compared against a rule-level model of the match.
`timescale 1ns/1ps

module tb_controle_partida;

    localparam int PV = 5;
    localparam int ES = 3;
    localparam int WP = 4;
    localparam int WE = 6;

    logic          clk = 1'b0;
    logic          reset, iniciar, pausa, tick, gol_esq, gol_dir;
    logic [WP-1:0] placar_esq, placar_dir;
    logic          saque, direcao_saque, congela_bola, ganhou, perdeu;
    logic [2:0]    db_estado;

    controle_partida #(
        .PONTOS_VITORIA(PV), .ESPERA_SAQUE(ES), .W_PLACAR(WP), .W_ESPERA(WE)
    ) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .pausa(pausa), .tick(tick),
        .gol_esq(gol_esq), .gol_dir(gol_dir),
        .placar_esq(placar_esq), .placar_dir(placar_dir), .saque(saque),
        .direcao_saque(direcao_saque), .congela_bola(congela_bola),
        .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Match model: phase of the point, serve ticks still owed, scores by side
    // (0 = left/player, 1 = right/opponent), serve direction and result flags.
    int m_fase  = 0;
    int m_falta = ES;
    int m_pts[2] = '{0, 0};
    int m_quem  = 0;
    bit m_dir   = 1'b1;
    bit m_venceu = 1'b0;
    bit m_perdeu = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void comeca_espera();
        m_fase  = 2;
        m_falta = ES;
    endfunction

    // Advances the model by one clock edge using the inputs present at that edge.
    function automatic void modelo();
        if (reset) begin
            m_fase = 0; m_pts = '{0, 0}; m_dir = 1'b1; m_venceu = 1'b0; m_perdeu = 1'b0;
            m_falta = ES;
            return;
        end
        case (m_fase)
            0: if (iniciar) m_fase = 1;
            1: begin
                m_pts = '{0, 0}; m_venceu = 1'b0; m_perdeu = 1'b0; m_dir = 1'b1;
                comeca_espera();
            end
            2: if (tick && !pausa) begin
                m_falta--;
                if (m_falta == 0) m_fase = 3;
            end
            3: m_fase = 4;
            4: if (!pausa && (gol_esq || gol_dir)) begin
                m_quem = gol_esq ? 1 : 0;
                m_fase = 5;
            end
            5: begin
                if (m_pts[m_quem] < (1 << WP) - 1) m_pts[m_quem]++;
                m_dir = (m_quem == 1);
                if (m_pts[m_quem] == PV) begin
                    m_fase = 6;
                    if (m_quem == 0) m_venceu = 1'b1; else m_perdeu = 1'b1;
                end else begin
                    comeca_espera();
                end
            end
            6: if (iniciar) m_fase = 1;
            default: m_fase = 0;
        endcase
    endfunction

    task automatic verifica();
        check("db_estado", 8'(db_estado), 8'(m_fase));
        check("placar_esq", 8'(placar_esq), 8'(m_pts[0]));
        check("placar_dir", 8'(placar_dir), 8'(m_pts[1]));
        check("saque", 8'(saque), 8'(m_fase == 3));
        check("congela_bola", 8'(congela_bola), 8'(!(m_fase == 4 && !pausa)));
        check("direcao_saque", 8'(direcao_saque), 8'(m_dir));
        check("ganhou", 8'(ganhou), 8'(m_venceu));
        check("perdeu", 8'(perdeu), 8'(m_perdeu));
    endtask

    // One clock: model and DUT take the same edge, outputs compared 1 ns later.
    task automatic passo();
        @(posedge clk);
        modelo();
        #1;
        verifica();
    endtask

    task automatic zera_entradas();
        reset = 1'b0; iniciar = 1'b0; pausa = 1'b0; tick = 1'b0;
        gol_esq = 1'b0; gol_dir = 1'b0;
    endtask

    int saque_em;

    initial begin
        zera_entradas();
        reset = 1'b1;
        passo();
        passo();
        check("reset_estado", 8'(db_estado), 8'd0);
        check("reset_congela", 8'(congela_bola), 8'd1);
        reset = 1'b0;

        // First serve: ticks every 4 cycles, three of them before the serve.
        iniciar = 1'b1; passo(); iniciar = 1'b0;
        saque_em = -1;
        for (int c = 0; c < 40; c++) begin
            tick = (c % 4 == 3);
            passo();
            if (saque && saque_em < 0) saque_em = c;
        end
        tick = 1'b0;
        check("primeiro_saque_ciclo", 8'(saque_em), 8'd11);
        check("em_jogo", 8'(db_estado), 8'd4);

        // Left side scores until it wins.
        for (int c = 0; c < 600 && m_fase != 6; c++) begin
            tick    = (c % 4 == 3);
            gol_dir = (m_fase == 4) && ($urandom_range(0, 2) == 0);
            passo();
        end
        gol_dir = 1'b0;
        check("ganhou_fim", 8'(ganhou), 8'd1);
        check("placar_esq_fim", 8'(placar_esq), 8'(PV));
        for (int c = 0; c < 20; c++) begin
            tick = (c % 4 == 3); gol_dir = c[0]; gol_esq = c[1];
            passo();
        end
        gol_dir = 1'b0; gol_esq = 1'b0; tick = 1'b0;

        // Restart; first ten ticks paused, so the serve waits for ticks 11..13.
        iniciar = 1'b1; passo(); iniciar = 1'b0;
        saque_em = -1;
        for (int c = 0; c < 80; c++) begin
            tick  = (c % 4 == 3);
            pausa = (c < 40);
            passo();
            if (saque && saque_em < 0) saque_em = c;
        end
        tick = 1'b0;
        check("saque_apos_pausa", 8'(saque_em), 8'd51);

        // Paused goals are ignored.
        pausa = 1'b1; gol_esq = 1'b1;
        for (int c = 0; c < 5; c++) passo();
        check("pausa_sem_gol", 8'(placar_dir), 8'd0);
        pausa = 1'b0;

        // Both goals together: only the right side scores.
        gol_dir = 1'b1; passo();
        gol_esq = 1'b0; gol_dir = 1'b0; passo();
        check("empate_dir", 8'(placar_dir), 8'd1);
        check("empate_esq", 8'(placar_esq), 8'd0);

        // Right side wins.
        for (int c = 0; c < 600 && m_fase != 6; c++) begin
            tick    = (c % 4 == 3);
            gol_esq = (m_fase == 4) && ($urandom_range(0, 2) == 0);
            passo();
        end
        gol_esq = 1'b0;
        check("perdeu_fim", 8'(perdeu), 8'd1);

        // Restart with iniciar held across FIM -> PREPARA.
        iniciar = 1'b1;
        for (int c = 0; c < 3; c++) passo();
        iniciar = 1'b0;
        check("reinicio_perdeu", 8'(perdeu), 8'd0);
        check("reinicio_placar", 8'(placar_dir), 8'd0);
        check("reinicio_direcao", 8'(direcao_saque), 8'd1);

        // Build up a few points, then reset in the middle of play.
        for (int c = 0; c < 600 && !(m_fase == 4 && m_pts[0] + m_pts[1] >= 3); c++) begin
            tick = (c % 4 == 3);
            if (m_fase == 4 && $urandom_range(0, 1) == 0) begin
                gol_esq = $urandom_range(0, 1);
                gol_dir = !gol_esq;
            end else begin
                gol_esq = 1'b0; gol_dir = 1'b0;
            end
            passo();
        end
        gol_esq = 1'b0; gol_dir = 1'b0; tick = 1'b0;
        check("jogo_antes_reset", 8'(db_estado), 8'd4);
        reset = 1'b1;
        #2;
        verifica();
        reset = 1'b0;
        passo();
        reset = 1'b1; passo(); reset = 1'b0;
        check("reset_jogo_estado", 8'(db_estado), 8'd0);
        check("reset_jogo_placar", 8'(placar_esq), 8'd0);

        // Randomized play, including occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 199) == 0);
            iniciar = ($urandom_range(0, 19) == 0);
            pausa   = ($urandom_range(0, 4) == 0);
            tick    = ($urandom_range(0, 2) == 0);
            gol_esq = ($urandom_range(0, 7) == 0);
            gol_dir = ($urandom_range(0, 7) == 0);
            passo();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
